// File: rtl/bcd_countdown_pkg.sv
// bcd_countdown_pkg: shared types and constants for the BCD down-counter.
// Holds the FSM state encoding, the BCD digit type and digit helper functions.
package bcd_countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cd_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'h9;
    localparam bcd_digit_t BCD_ZERO = 4'h0;

    // True when a nibble is not a legal BCD digit.
    function automatic logic bcd_is_bad(input bcd_digit_t d);
        return (d > BCD_MAX);
    endfunction

    // Clamp an illegal nibble to the largest BCD digit.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return bcd_is_bad(d) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_countdown_dec.sv
// bcd_digit_dec: single BCD digit decrement with borrow.
// A digit at zero wraps to nine and requests a borrow from the next digit.
module bcd_digit_dec
    import bcd_countdown_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] digit_next,
    output logic       borrow_out
);

    // Subtract the incoming borrow from this digit, wrapping 0 to 9.
    always_comb begin
        digit_next = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (bcd_digit_t'(digit) == BCD_ZERO) begin
                digit_next = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - 4'd1;
                borrow_out = 1'b0;
            end
        end else begin
            digit_next = digit;
            borrow_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_countdown.sv
// bcd_countdown: multi-digit BCD down-counter with load, start and a
// one-cycle terminal pulse. Optional macro BCD_COUNTDOWN_AUTORELOAD_EN adds a
// reload register so the counter restarts from the last loaded value after
// each terminal count.
module bcd_countdown
    import bcd_countdown_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [4*DIGITS-1:0] CNT_ZERO = {(4*DIGITS){1'b0}};

    cd_state_t             state_r;
    cd_state_t             state_s;
    logic [4*DIGITS-1:0]   cnt_r;
    logic [4*DIGITS-1:0]   cnt_s;
    logic                  err_r;
    logic                  err_s;
    logic [4*DIGITS-1:0]   load_clean_s;
    logic                  load_bad_s;
    logic [4*DIGITS-1:0]   cnt_dec_s;
    logic [DIGITS:0]       borrow_s;
    logic                  cnt_zero_s;
    logic                  cnt_one_s;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    logic [4*DIGITS-1:0]   reload_r;
`endif

    // Ripple-borrow decrement chain; a borrow out of the top digit means cnt==0.
    assign borrow_s[0] = 1'b1;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dec
        bcd_digit_dec u_dec (
            .digit      (cnt_r[4*gi +: 4]),
            .borrow_in  (borrow_s[gi]),
            .digit_next (cnt_dec_s[4*gi +: 4]),
            .borrow_out (borrow_s[gi+1])
        );
    end

    assign cnt_zero_s = borrow_s[DIGITS];
    assign cnt_one_s  = (cnt_dec_s == CNT_ZERO) && !cnt_zero_s;

    // Clamp illegal load nibbles to 9 and flag whether any were clamped.
    always_comb begin
        load_clean_s = CNT_ZERO;
        load_bad_s   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clean_s[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
            if (bcd_is_bad(load_val[4*i +: 4])) begin
                load_bad_s = 1'b1;
            end else begin
                load_bad_s = load_bad_s;
            end
        end
    end

    // Next-state and next-count logic; load beats start, start beats en.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        if (load) begin
            cnt_s   = load_clean_s;
            err_s   = load_bad_s;
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = cnt_zero_s ? ST_DONE : ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Zero is never decremented, so the count cannot wrap.
                    if (en && !cnt_zero_s) begin
                        cnt_s   = cnt_dec_s;
                        state_s = cnt_one_s ? ST_DONE : ST_RUN;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_DONE: begin
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
                    cnt_s   = reload_r;
                    state_s = (reload_r != CNT_ZERO) ? ST_RUN : ST_IDLE;
`else
                    state_s = ST_IDLE;
`endif
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, count and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
        end
    end

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    // Reload register remembers the last sanitized load value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload_r <= CNT_ZERO;
        end else if (load) begin
            reload_r <= load_clean_s;
        end else begin
            reload_r <= reload_r;
        end
    end
`endif

    assign cnt  = cnt_r;
    assign err  = err_r;
    assign busy = (state_r == ST_RUN);
    assign done = (state_r == ST_DONE);

endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown: directed plus randomized checks of bcd_countdown against
// an integer-valued reference model (count kept as a plain decimal number).
module tb_bcd_countdown;

    localparam int DIGITS = 2;
    localparam int W      = 4*DIGITS;

    logic           clk;
    logic           rst;
    logic           load;
    logic [W-1:0]   load_val;
    logic           start;
    logic           en;
    logic [W-1:0]   cnt;
    logic           busy;
    logic           done;
    logic           err;

    int n_checks;
    int n_errors;

    // Reference model: decimal value, phase (0 idle, 1 run, 2 done), error, reload.
    int m_val;
    int m_ph;
    int m_rl;
    bit m_err;

    bcd_countdown #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .en       (en),
        .cnt      (cnt),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_val = 0; m_ph = 0; m_rl = 0; m_err = 1'b0;
    endtask

    task automatic model_edge();
        int nib, mult, v;
        bit bad;
        if (load) begin
            v = 0; mult = 1; bad = 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                nib = int'((load_val >> (4*i)) & 15);
                if (nib > 9) begin nib = 9; bad = 1'b1; end
                v += nib * mult;
                mult *= 10;
            end
            m_val = v; m_err = bad; m_rl = v; m_ph = 0;
        end else if (m_ph == 0) begin
            if (start) m_ph = (m_val == 0) ? 2 : 1;
        end else if (m_ph == 1) begin
            if (en && m_val > 0) begin
                m_val--;
                if (m_val == 0) m_ph = 2;
            end
        end else begin
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
            m_val = m_rl;
            m_ph  = (m_rl != 0) ? 1 : 0;
`else
            m_ph  = 0;
`endif
        end
    endtask

    task automatic check_all();
        check_eq("cnt",  32'(cnt),  to_bcd(m_val));
        check_eq("busy", 32'(busy), 32'(m_ph == 1));
        check_eq("done", 32'(done), 32'(m_ph == 2));
        check_eq("err",  32'(err),  32'(m_err));
    endtask

    // One clock with the given inputs, then compare against the model.
    task automatic cyc(input logic l, input logic [W-1:0] lv, input logic s, input logic e);
        load = l; load_val = lv; start = s; en = e;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Reset pulse placed between clock edges; outputs must clear immediately.
    task automatic async_reset();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_eq("rst_cnt",  32'(cnt),  32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_err",  32'(err),  32'h0);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; en = 1'b0;
        model_reset();
        #2;
        check_eq("reset_cnt",  32'(cnt),  32'h0);
        check_eq("reset_busy", 32'(busy), 32'h0);
        check_eq("reset_done", 32'(done), 32'h0);
        check_eq("reset_err",  32'(err),  32'h0);
        #6;
        rst = 1'b1;

        // Count 12 down to 00 with en held high.
        cyc(1'b1, 8'h12, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("run_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("term_cnt",  32'(cnt),  32'h0);
        check_eq("term_done", 32'(done), 32'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("post_done", 32'(done), 32'h0);

        // Illegal nibble clamps and sets err; a clean load clears it.
        cyc(1'b1, 8'h3A, 1'b0, 1'b0);
        check_eq("clamp_cnt", 32'(cnt), 32'h39);
        check_eq("clamp_err", 32'(err), 32'h1);
        cyc(1'b1, 8'h05, 1'b0, 1'b0);
        check_eq("clean_err", 32'(err), 32'h0);

        // en toggling 1,0,0 only adds latency.
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) cyc(1'b0, 8'h00, 1'b0, (i % 3) == 0);

        // Reset in the middle of a count at 07.
        cyc(1'b1, 8'h09, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("pre_rst_cnt", 32'(cnt), 32'h07);
        async_reset();

        // Load during RUN aborts without a done pulse.
        cyc(1'b1, 8'h09, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h04, 1'b0, 1'b1);
        check_eq("abort_cnt",  32'(cnt),  32'h04);
        check_eq("abort_busy", 32'(busy), 32'h0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("abort_done", 32'(done), 32'h0);

        // Start at zero goes straight to done; load beats start.
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("zero_done", 32'(done), 32'h1);
        check_eq("zero_busy", 32'(busy), 32'h0);
        cyc(1'b1, 8'h21, 1'b1, 1'b1);
        check_eq("ld_st_busy", 32'(busy), 32'h0);

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        cyc(1'b1, 8'h03, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("ar_zero_idle", 32'(busy), 32'h0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] lv;
            lv = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 8'h19)) : W'($urandom);
            cyc($urandom_range(0, 99) < 4, lv, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 70);
            if ((i % 401) == 400) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
